// File: rtl/smac_pkg.sv
// smac_pkg: shared types and helpers for the packed-SIMD sub-MAC.
//   prec_t      - per-beat precision tag (INT8 / INT16 / INT32 / reserved)
//   lane_width  - lane width in bits for a precision tag
//   num_lanes   - number of lanes of a given precision in a DATA_W word
package smac_pkg;

    typedef enum logic [1:0] {
        PREC_INT8  = 2'd0,
        PREC_INT16 = 2'd1,
        PREC_INT32 = 2'd2,
        PREC_RSVD  = 2'd3
    } prec_t;

    localparam int unsigned SEG_W = 32;

    // Reserved precision is processed as INT32.
    function automatic int unsigned lane_width(input prec_t p);
        case (p)
            PREC_INT8:  return 8;
            PREC_INT16: return 16;
            default:    return 32;
        endcase
    endfunction

    function automatic int unsigned num_lanes(input int unsigned data_w, input prec_t p);
        return data_w / lane_width(p);
    endfunction

endpackage

// File: rtl/smac_simd_seg.sv
// smac_simd_seg: one 32-bit segment of the SIMD sub-MAC (S2 products, S3 add/saturate).
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   en_i               stage advance (shared with the top-level valid chain)
//   prec_s1_i          tag of the beat in S1 (selects product layout)
//   a_i, b_i, c_i      S1 operand slices for this segment
//   prec_s2_i          tag of the beat in S2 (selects add/saturate layout)
//   res_o, ovf_o       S3 registered lane results and segment overflow flag
module smac_simd_seg
    import smac_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  prec_t       prec_s1_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  prec_t       prec_s2_i,
    output logic [31:0] res_o,
    output logic        ovf_o
);

    logic [63:0] prod_d, prod_q;
    logic [31:0] c_q;
    logic [31:0] res_d, res_q;
    logic        ovf_d, ovf_q;
    logic [16:0] s8;
    logic [32:0] s16;
    logic [64:0] s32;

    // Products are kept as 2W-bit fields packed in one 64-bit word:
    // 4x16 for INT8, 2x32 for INT16, 1x64 for INT32. Sign-extending the
    // operands to 2W bits makes the low 2W bits of the product exact.
    always_comb begin
        prod_d = '0;
        case (prec_s1_i)
            PREC_INT8: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    prod_d[k*16 +: 16] = {{8{a_i[k*8+7]}}, a_i[k*8 +: 8]}
                                       * {{8{b_i[k*8+7]}}, b_i[k*8 +: 8]};
                end
            end
            PREC_INT16: begin
                for (int unsigned k = 0; k < 2; k++) begin
                    prod_d[k*32 +: 32] = {{16{a_i[k*16+15]}}, a_i[k*16 +: 16]}
                                       * {{16{b_i[k*16+15]}}, b_i[k*16 +: 16]};
                end
            end
            default: begin
                prod_d = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
            end
        endcase
    end

    // A 2W+1-bit sum fits in W signed bits iff bits [2W:W-1] are all equal.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        s8    = '0;
        s16   = '0;
        s32   = '0;
        case (prec_s2_i)
            PREC_INT8: begin
                for (int unsigned k = 0; k < 4; k++) begin
                    s8 = {prod_q[k*16+15], prod_q[k*16 +: 16]}
                       + {{9{c_q[k*8+7]}}, c_q[k*8 +: 8]};
                    if (!((&s8[16:7]) || !(|s8[16:7]))) begin
                        ovf_d = 1'b1;
                        res_d[k*8 +: 8] = SATURATE ? (s8[16] ? 8'h80 : 8'h7F) : s8[7:0];
                    end else begin
                        res_d[k*8 +: 8] = s8[7:0];
                    end
                end
            end
            PREC_INT16: begin
                for (int unsigned k = 0; k < 2; k++) begin
                    s16 = {prod_q[k*32+31], prod_q[k*32 +: 32]}
                        + {{17{c_q[k*16+15]}}, c_q[k*16 +: 16]};
                    if (!((&s16[32:15]) || !(|s16[32:15]))) begin
                        ovf_d = 1'b1;
                        res_d[k*16 +: 16] = SATURATE ? (s16[32] ? 16'h8000 : 16'h7FFF) : s16[15:0];
                    end else begin
                        res_d[k*16 +: 16] = s16[15:0];
                    end
                end
            end
            default: begin
                s32 = {prod_q[63], prod_q} + {{33{c_q[31]}}, c_q};
                if (!((&s32[64:31]) || !(|s32[64:31]))) begin
                    ovf_d = 1'b1;
                    res_d = SATURATE ? (s32[64] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s32[31:0];
                end else begin
                    res_d = s32[31:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q <= '0;
            c_q    <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            prod_q <= prod_d;
            c_q    <= c_i;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/smac_simd.sv
// smac_simd: packed-SIMD signed sub-MAC, P = A*B + C per lane, 3-stage pipeline
// with valid/ready backpressure, per-beat precision tag and optional saturation.
// Ports:
//   clk, rst_n, ce, sclr                   clock, async reset, clock enable, sync clear
//   in_valid/in_ready, prec                input handshake and precision tag
//   data_input, weight, res_mac_p          packed A, B, C operands
//   out_valid/out_ready                    output handshake
//   res_mac_n, out_prec, out_ovf, out_err  packed result and per-beat flags
//   ovf_sticky                             overflow seen on any delivered beat
module smac_simd
    import smac_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              sclr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        prec,
    input  logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] res_mac_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res_mac_n,
    output logic [1:0]        out_prec,
    output logic              out_ovf,
    output logic              out_err,
    output logic              ovf_sticky
);

    localparam int unsigned NSEG = num_lanes(DATA_W, PREC_INT32);

    logic              init_q;
    logic              adv;
    logic              v1_q, v2_q, v3_q;
    prec_t             prec1_q, prec2_q, prec3_q;
    logic [DATA_W-1:0] a1_q, b1_q, c1_q;
    logic              sticky_d, sticky_q;
    logic [NSEG-1:0]   seg_ovf;

    // init_q keeps in_ready low until the first edge after reset release.
    assign adv      = ce & init_q & (~v3_q | out_ready);
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 1'b0;
        else        init_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (sclr) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            b1_q    <= '0;
            c1_q    <= '0;
            prec1_q <= PREC_INT8;
            prec2_q <= PREC_INT8;
            prec3_q <= PREC_INT8;
        end else if (adv) begin
            a1_q    <= data_input;
            b1_q    <= weight;
            c1_q    <= res_mac_p;
            prec1_q <= prec_t'(prec);
            prec2_q <= prec1_q;
            prec3_q <= prec2_q;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        smac_simd_seg #(
            .SATURATE (SATURATE)
        ) u_seg (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .en_i      (adv),
            .prec_s1_i (prec1_q),
            .a_i       (a1_q[g*32 +: 32]),
            .b_i       (b1_q[g*32 +: 32]),
            .c_i       (c1_q[g*32 +: 32]),
            .prec_s2_i (prec2_q),
            .res_o     (res_mac_n[g*32 +: 32]),
            .ovf_o     (seg_ovf[g])
        );
    end

    assign out_ovf = |seg_ovf;

    // A beat only leaves when the pipeline moves, so delivery is gated by ce.
    always_comb begin
        sticky_d = sticky_q;
        if (sclr)                                 sticky_d = 1'b0;
        else if (ce & v3_q & out_ready & out_ovf) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign out_valid  = v3_q;
    assign out_prec   = prec3_q;
    assign out_err    = (prec3_q == PREC_RSVD);
    assign ovf_sticky = sticky_q;

endmodule
